alien_rocket_scheduler: RTL and testbench

- Shares the single alien-rocket drawing object (the a_rocket1 layer feeding the objects mux) among NUM_SHOOTERS alien columns.
- Round-robin arbitrates column fire requests and issues a one-cycle launch with start coordinates to the rocket object.
- Holds the grant while the rocket is in flight, then enforces a frame-counted cooldown before the next launch.

---
 rtl/alien_rocket_scheduler_pkg.sv | 17 +
 rtl/alien_rocket_scheduler_rr_arbiter.sv | 49 ++++
 rtl/alien_rocket_scheduler.sv | 159 +++++++++++++++
 tb/tb_alien_rocket_scheduler.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alien_rocket_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// alien_rocket_pkg
// Shared types and constants for the alien-rocket scheduler and its arbiter.
//   sched_state_t : scheduler FSM states (IDLE, FLIGHT, COOLDOWN)
//   COORD_W       : pixel coordinate width used by the rocket object
// ---------------------------------------------------------------------------
package alien_rocket_pkg;

    localparam int COORD_W = 11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLIGHT   = 2'd1,
        COOLDOWN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/alien_rocket_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set request bit found
// searching upward from ptr, wrapping past N-1 back to 0.
// Ports:
//   req    in  N      request vector, bit i = requester i
//   ptr    in  IDX_W  highest-priority index for this pick (must be < N)
//   onehot out N      one-hot of the winner, 0 when no request
//   idx    out IDX_W  winner index, 0 when no request
//   any    out 1      at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk offsets from the farthest to the nearest so the nearest set bit
    // (relative to ptr) is the last assignment and therefore wins.
    always_comb begin
        cand     = 0;
        cand_idx = '0;
        idx      = '0;
        onehot   = '0;
        any      = |req;
        for (int k = N - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                idx = cand_idx;
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alien_rocket_scheduler.sv
// ---------------------------------------------------------------------------
// alien_rocket_scheduler
// Shares the single alien-rocket drawing object among NUM_SHOOTERS columns.
// Round-robin picks a firing column, pulses launch with its start pixel,
// holds the grant while the rocket flies, then waits a frame-counted
// cooldown before the next launch. All outputs are registered.
// Ports:
//   clk             in   1             pixel clock
//   resetN          in   1             asynchronous active-low reset
//   startOfFrame    in   1             one-cycle pulse per VGA frame
//   enable          in   1             game running; gates new launches only
//   fire_req        in   NUM_SHOOTERS  level fire request per column
//   rocket_done     in   1             rocket hit something or left screen
//   launch          out  1             one-cycle load strobe to rocket object
//   launch_x        out  11            launch X pixel (held after launch)
//   launch_y        out  11            launch Y pixel (held after launch)
//   grant           out  NUM_SHOOTERS  one-hot owning column during FLIGHT
//   rocket_busy     out  1             high in FLIGHT
//   cooldown_active out  1             high in COOLDOWN
// ---------------------------------------------------------------------------
module alien_rocket_scheduler
    import alien_rocket_pkg::*;
#(
    parameter int NUM_SHOOTERS      = 8,
    parameter int COL_X0            = 64,
    parameter int COL_PITCH         = 64,
    parameter int LAUNCH_Y          = 120,
    parameter int COOLDOWN_FRAMES   = 30,
    parameter int MAX_FLIGHT_FRAMES = 255
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    enable,
    input  logic [NUM_SHOOTERS-1:0] fire_req,
    input  logic                    rocket_done,
    output logic                    launch,
    output logic [COORD_W-1:0]      launch_x,
    output logic [COORD_W-1:0]      launch_y,
    output logic [NUM_SHOOTERS-1:0] grant,
    output logic                    rocket_busy,
    output logic                    cooldown_active
);

    localparam int IDX_W = $clog2(NUM_SHOOTERS);
    localparam int FW    = (MAX_FLIGHT_FRAMES > 1) ? $clog2(MAX_FLIGHT_FRAMES + 1) : 1;
    localparam int CW    = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [FW:0] FLIGHT_LIMIT = (FW + 1)'(MAX_FLIGHT_FRAMES);

    sched_state_t state, state_n;
    logic [IDX_W-1:0]        ptr, ptr_n;
    logic [FW-1:0]           flight_cnt, flight_n;
    logic [CW-1:0]           cool_cnt, cool_n;
    logic                    launch_n;
    logic [COORD_W-1:0]      x_n, y_n, x_calc;
    logic [NUM_SHOOTERS-1:0] grant_n, win_onehot;
    logic [IDX_W-1:0]        win_idx;
    logic                    req_any;
    logic                    watchdog_hit;
    logic                    flight_end;

    rr_arbiter #(
        .N     (NUM_SHOOTERS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (fire_req),
        .ptr    (ptr),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (req_any)
    );

    // Position math is done at the coordinate width on purpose: a column
    // placed past the screen edge wraps rather than saturating.
    assign x_calc = COORD_W'(COL_X0) + COORD_W'(win_idx) * COORD_W'(COL_PITCH);

    // True when the next frame would bring the flight to its watchdog limit.
    assign watchdog_hit = ({1'b0, flight_cnt} + 1'b1) == FLIGHT_LIMIT;

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        flight_n   = flight_cnt;
        cool_n     = cool_cnt;
        launch_n   = 1'b0;
        x_n        = launch_x;
        y_n        = launch_y;
        grant_n    = grant;
        flight_end = 1'b0;
        case (state)
            IDLE: begin
                if (enable && req_any) begin
                    launch_n = 1'b1;
                    x_n      = x_calc;
                    y_n      = COORD_W'(LAUNCH_Y);
                    grant_n  = win_onehot;
                    state_n  = FLIGHT;
                    ptr_n    = (int'(win_idx) == NUM_SHOOTERS - 1) ? '0 : win_idx + 1'b1;
                    flight_n = '0;
                end
            end
            FLIGHT: begin
                if (startOfFrame && (flight_cnt != '1)) begin
                    flight_n = flight_cnt + 1'b1;
                end
                // A real end and a watchdog expiry in one cycle are one end.
                flight_end = rocket_done || (startOfFrame && watchdog_hit);
                if (flight_end) begin
                    grant_n = '0;
                    if (COOLDOWN_FRAMES == 0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = COOLDOWN;
                        cool_n  = CW'(COOLDOWN_FRAMES);
                    end
                end
            end
            COOLDOWN: begin
                if (startOfFrame) begin
                    cool_n = cool_cnt - 1'b1;
                    if (cool_cnt == CW'(1)) begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state           <= IDLE;
            ptr             <= '0;
            flight_cnt      <= '0;
            cool_cnt        <= '0;
            launch          <= 1'b0;
            launch_x        <= '0;
            launch_y        <= '0;
            grant           <= '0;
            rocket_busy     <= 1'b0;
            cooldown_active <= 1'b0;
        end else begin
            state           <= state_n;
            ptr             <= ptr_n;
            flight_cnt      <= flight_n;
            cool_cnt        <= cool_n;
            launch          <= launch_n;
            launch_x        <= x_n;
            launch_y        <= y_n;
            grant           <= grant_n;
            rocket_busy     <= (state_n == FLIGHT);
            cooldown_active <= (state_n == COOLDOWN);
        end
    end

endmodule

// File: tb/tb_alien_rocket_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alien_rocket_scheduler
// Self-checking bench for alien_rocket_scheduler (8 columns, cooldown of
// 2 frames, watchdog of 4 frames). Expected launches are queued when the
// request is driven and checked when the DUT pulses launch.
// ---------------------------------------------------------------------------
module tb_alien_rocket_scheduler;

    localparam int N = 8;

    logic          clk          = 1'b0;
    logic          resetN       = 1'b0;
    logic          startOfFrame = 1'b0;
    logic          enable       = 1'b0;
    logic          rocket_done  = 1'b0;
    logic [N-1:0]  fire_req     = '0;
    logic          launch;
    logic [10:0]   launch_x;
    logic [10:0]   launch_y;
    logic [N-1:0]  grant;
    logic          rocket_busy;
    logic          cooldown_active;

    typedef struct packed {
        logic [10:0]  x;
        logic [10:0]  y;
        logic [N-1:0] g;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    alien_rocket_scheduler #(
        .NUM_SHOOTERS      (N),
        .COL_X0            (64),
        .COL_PITCH         (64),
        .LAUNCH_Y          (120),
        .COOLDOWN_FRAMES   (2),
        .MAX_FLIGHT_FRAMES (4)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .enable          (enable),
        .fire_req        (fire_req),
        .rocket_done     (rocket_done),
        .launch          (launch),
        .launch_x        (launch_x),
        .launch_y        (launch_y),
        .grant           (grant),
        .rocket_busy     (rocket_busy),
        .cooldown_active (cooldown_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof_tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    function automatic exp_t col_exp(input int c);
        exp_t e;
        e.x = 11'(64 + c * 64);
        e.y = 11'd120;
        e.g = N'(1 << c);
        return e;
    endfunction

    // Bounded wait for the launch strobe; lat = cycles waited.
    task automatic wait_launch(output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (launch === 1'b1) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
    endtask

    // End the current flight and run out the 2-frame cooldown.
    task automatic end_flight();
        rocket_done = 1'b1;
        tick();
        rocket_done = 1'b0;
        tick();
        sof_tick();
        tick();
        sof_tick();
        tick();
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if ({launch, launch_x, launch_y, grant, rocket_busy, cooldown_active} !== '0) begin
            n_err++;
            $display("FAIL reset_state: launch=%b x=%0d y=%0d grant=%h busy=%b cool=%b, expected all 0",
                     launch, launch_x, launch_y, grant, rocket_busy, cooldown_active);
        end
        tick();
        resetN = 1'b1;
    endtask

    task automatic test_idle();
        bit bad = 1'b0;
        fire_req = '0;
        enable   = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                if ({launch, grant, rocket_busy, cooldown_active} !== '0) bad = 1'b1;
            end
            sof_tick();
            if ({launch, grant, rocket_busy, cooldown_active} !== '0) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL idle_no_request: outputs went active with fire_req=0, expected idle");
        end
        enable   = 1'b0;
        fire_req = '1;
        bad      = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (launch !== 1'b0 || rocket_busy !== 1'b0) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL enable_gate: launch=%b busy=%b with enable=0, expected 0", launch, rocket_busy);
        end
    endtask

    task automatic test_single();
        bit   got;
        int   lat;
        exp_t e;
        fire_req = 8'b0000_1000;
        enable   = 1'b1;
        sb.push_back(col_exp(3));
        wait_launch(got, lat);
        n_vec++;
        if (!got || lat != 1 || sb.size() == 0) begin
            n_err++;
            $display("FAIL single_latency: got=%0d latency=%0d, expected launch after 1 cycle", got, lat);
        end else begin
            e = sb.pop_front();
            n_vec++;
            if (launch_x !== e.x || launch_y !== e.y || grant !== e.g || rocket_busy !== 1'b1) begin
                n_err++;
                $display("FAIL single_launch: x=%0d y=%0d grant=%h busy=%b, expected x=%0d y=%0d grant=%h busy=1",
                         launch_x, launch_y, grant, rocket_busy, e.x, e.y, e.g);
            end
        end
        fire_req = '0;
        tick();
        n_vec++;
        if (launch !== 1'b0 || launch_x !== 11'd256 || launch_y !== 11'd120 || grant !== 8'h08) begin
            n_err++;
            $display("FAIL single_hold: launch=%b x=%0d y=%0d grant=%h, expected 0/256/120/08",
                     launch, launch_x, launch_y, grant);
        end
        enable = 1'b0;
        tick();
        sof_tick();
        tick();
        n_vec++;
        if (rocket_busy !== 1'b1 || grant !== 8'h08) begin
            n_err++;
            $display("FAIL flight_ignores_enable: busy=%b grant=%h, expected 1/08", rocket_busy, grant);
        end
        enable      = 1'b1;
        rocket_done = 1'b1;
        tick();
        rocket_done = 1'b0;
        n_vec++;
        if (grant !== '0 || rocket_busy !== 1'b0 || cooldown_active !== 1'b1) begin
            n_err++;
            $display("FAIL done_to_cooldown: grant=%h busy=%b cool=%b, expected 00/0/1",
                     grant, rocket_busy, cooldown_active);
        end
        tick();
        sof_tick();
        tick();
        sof_tick();
        n_vec++;
        if (cooldown_active !== 1'b0 || rocket_busy !== 1'b0) begin
            n_err++;
            $display("FAIL cooldown_exit: cool=%b busy=%b, expected 0/0", cooldown_active, rocket_busy);
        end
        // Pointer moved past column 3, so column 4 beats column 3.
        fire_req = 8'b0001_1000;
        sb.push_back(col_exp(4));
        wait_launch(got, lat);
        n_vec++;
        if (!got || sb.size() == 0) begin
            n_err++;
            $display("FAIL pointer_advance: got=%0d, expected a launch", got);
        end else begin
            e = sb.pop_front();
            if (launch_x !== e.x || grant !== e.g) begin
                n_err++;
                $display("FAIL pointer_advance: x=%0d grant=%h, expected x=%0d grant=%h",
                         launch_x, grant, e.x, e.g);
            end
        end
        fire_req = '0;
        end_flight();
    endtask

    task automatic test_round_robin();
        bit   got;
        int   lat;
        int   n_sof;
        exp_t e;
        resetN = 1'b0;
        tick();
        resetN   = 1'b1;
        fire_req = '1;
        enable   = 1'b1;
        for (int w = 0; w <= 8; w++) sb.push_back(col_exp(w % 8));
        for (int i = 0; i <= 8; i++) begin
            if (i == 0) begin
                wait_launch(got, lat);
            end else begin
                n_sof = 0;
                got   = 1'b0;
                for (int c = 0; c < 60; c++) begin
                    startOfFrame = (c % 4 == 3);
                    if (startOfFrame) n_sof++;
                    tick();
                    startOfFrame = 1'b0;
                    if (launch === 1'b1) begin
                        got = 1'b1;
                        break;
                    end
                end
                n_vec++;
                if (!got || n_sof != 2) begin
                    n_err++;
                    $display("FAIL rr_cooldown_%0d: got=%0d frames=%0d, expected launch after 2 frames",
                             i, got, n_sof);
                end
            end
            n_vec++;
            if (!got || sb.size() == 0) begin
                n_err++;
                $display("FAIL rr_winner_%0d: no launch seen, expected column %0d", i, i % 8);
                break;
            end
            e = sb.pop_front();
            if (launch_x !== e.x || launch_y !== e.y || grant !== e.g) begin
                n_err++;
                $display("FAIL rr_winner_%0d: x=%0d grant=%h, expected x=%0d grant=%h",
                         i, launch_x, grant, e.x, e.g);
            end
            if (i < 8) begin
                tick();
                sof_tick();
                tick();
                sof_tick();
                rocket_done = 1'b1;
                tick();
                rocket_done = 1'b0;
            end
        end
        sb.delete();
        fire_req = '0;
        end_flight();
    endtask

    task automatic test_watchdog();
        bit   got;
        int   lat;
        exp_t e;
        fire_req = 8'h02;
        sb.push_back(col_exp(1));
        wait_launch(got, lat);
        n_vec++;
        if (!got || sb.size() == 0) begin
            n_err++;
            $display("FAIL wd_launch: got=%0d, expected a launch", got);
        end else begin
            e = sb.pop_front();
            if (launch_x !== e.x || grant !== e.g) begin
                n_err++;
                $display("FAIL wd_launch: x=%0d grant=%h, expected x=%0d grant=%h", launch_x, grant, e.x, e.g);
            end
        end
        fire_req = '0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            sof_tick();
            n_vec++;
            if (rocket_busy !== 1'b1 || grant !== 8'h02) begin
                n_err++;
                $display("FAIL wd_frame_%0d: busy=%b grant=%h, expected 1/02", k, rocket_busy, grant);
            end
        end
        tick();
        sof_tick();
        n_vec++;
        if (rocket_busy !== 1'b0 || grant !== '0 || cooldown_active !== 1'b1) begin
            n_err++;
            $display("FAIL wd_expire: busy=%b grant=%h cool=%b, expected 0/00/1",
                     rocket_busy, grant, cooldown_active);
        end
        tick();
        sof_tick();
        tick();
        sof_tick();
        tick();
    endtask

    task automatic test_same_cycle();
        bit   got;
        int   lat;
        exp_t e;
        fire_req = 8'h04;
        sb.push_back(col_exp(2));
        wait_launch(got, lat);
        n_vec++;
        if (!got || sb.size() == 0) begin
            n_err++;
            $display("FAIL same_launch: got=%0d, expected a launch", got);
        end else begin
            e = sb.pop_front();
            if (launch_x !== e.x || grant !== e.g) begin
                n_err++;
                $display("FAIL same_launch: x=%0d grant=%h, expected x=%0d grant=%h", launch_x, grant, e.x, e.g);
            end
        end
        fire_req = '0;
        tick();
        rocket_done  = 1'b1;
        startOfFrame = 1'b1;
        tick();
        rocket_done  = 1'b0;
        startOfFrame = 1'b0;
        n_vec++;
        if (cooldown_active !== 1'b1 || rocket_busy !== 1'b0) begin
            n_err++;
            $display("FAIL same_entry: cool=%b busy=%b, expected 1/0", cooldown_active, rocket_busy);
        end
        tick();
        sof_tick();
        n_vec++;
        if (cooldown_active !== 1'b1) begin
            n_err++;
            $display("FAIL same_no_entry_decrement: cool=%b after first frame, expected 1", cooldown_active);
        end
        tick();
        sof_tick();
        n_vec++;
        if (cooldown_active !== 1'b0 || rocket_busy !== 1'b0) begin
            n_err++;
            $display("FAIL same_exit: cool=%b busy=%b after second frame, expected 0/0",
                     cooldown_active, rocket_busy);
        end
    endtask

    task automatic test_reset_mid_flight();
        bit   got;
        int   lat;
        exp_t e;
        fire_req = 8'h20;
        sb.push_back(col_exp(5));
        wait_launch(got, lat);
        n_vec++;
        if (!got || sb.size() == 0) begin
            n_err++;
            $display("FAIL midreset_launch: got=%0d, expected a launch", got);
        end else begin
            e = sb.pop_front();
            if (grant !== e.g || launch_x !== e.x) begin
                n_err++;
                $display("FAIL midreset_launch: x=%0d grant=%h, expected x=%0d grant=%h", launch_x, grant, e.x, e.g);
            end
        end
        tick();
        #2;
        resetN = 1'b0;
        #1;
        n_vec++;
        if (grant !== '0 || rocket_busy !== 1'b0 || launch !== 1'b0 || launch_x !== '0) begin
            n_err++;
            $display("FAIL midreset_async: grant=%h busy=%b launch=%b x=%0d, expected all 0",
                     grant, rocket_busy, launch, launch_x);
        end
        sb.push_back(col_exp(5));
        #1;
        resetN = 1'b1;
        wait_launch(got, lat);
        n_vec++;
        if (!got || sb.size() == 0) begin
            n_err++;
            $display("FAIL midreset_relaunch: got=%0d, expected a launch", got);
        end else begin
            e = sb.pop_front();
            if (grant !== e.g || launch_x !== e.x || rocket_busy !== 1'b1) begin
                n_err++;
                $display("FAIL midreset_relaunch: x=%0d grant=%h busy=%b, expected x=%0d grant=%h busy=1",
                         launch_x, grant, rocket_busy, e.x, e.g);
            end
        end
        fire_req = '0;
        end_flight();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_round_robin();
        test_watchdog();
        test_same_cycle();
        test_reset_mid_flight();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d launches outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
